// File: rtl/fft_input_loader_if.sv
// ==== fft_input_loader_if : sample stream in, parallel 8-slot frame out (rev 1.0) ====
`default_nettype none

interface fft_input_loader_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic           in_last;
  logic [W-1:0]   in_r;
  logic [W-1:0]   in_i;
  logic           frame_valid;
  logic           frame_ready;
  logic [8*W-1:0] out_r;
  logic [8*W-1:0] out_i;
  logic           frame_err;

  // The loader side: consumes samples, produces frames.
  modport slave (
    input  in_valid, in_last, in_r, in_i, frame_ready,
    output in_ready, frame_valid, out_r, out_i, frame_err
  );

  // The environment side: produces samples, consumes frames.
  modport master (
    output in_valid, in_last, in_r, in_i, frame_ready,
    input  in_ready, frame_valid, out_r, out_i, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/fft_input_loader.sv
// ==== fft_input_loader : collects 8 complex samples into bit-reversed slots for the FFT (rev 1.0) ====
`default_nettype none

module fft_input_loader #(
  parameter int N      = 3,
  parameter bit BITREV = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fft_input_loader_if.slave bus
);

  localparam int W = 2 ** N;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e       state_q;
  logic [2:0]   cnt_q;
  logic         in_ready_q;
  logic         frame_valid_q;
  logic         frame_err_q;
  logic [W-1:0] slot_r_q [8];
  logic [W-1:0] slot_i_q [8];

  logic [2:0]   wr_idx;
  logic [2:0]   cnt_d;

  assign wr_idx = BITREV ? {cnt_q[0], cnt_q[1], cnt_q[2]} : cnt_q;
  assign cnt_d  = cnt_q + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FILL;
      cnt_q         <= 3'd0;
      in_ready_q    <= 1'b1;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        slot_r_q[k] <= '0;
        slot_i_q[k] <= '0;
      end
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (bus.in_valid) begin
            slot_r_q[wr_idx] <= bus.in_r;
            slot_i_q[wr_idx] <= bus.in_i;
            if (cnt_q == 3'd7) begin
              // A missing in_last on the 8th sample still completes the frame, but is flagged.
              state_q       <= FULL;
              cnt_q         <= 3'd0;
              in_ready_q    <= 1'b0;
              frame_valid_q <= 1'b1;
              frame_err_q   <= ~bus.in_last;
            end else if (bus.in_last) begin
              cnt_q       <= 3'd0;
              frame_err_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        FULL: begin
          if (bus.frame_ready) begin
            state_q       <= FILL;
            in_ready_q    <= 1'b1;
            frame_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= FILL;
          in_ready_q    <= 1'b1;
          frame_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;

  for (genvar k = 0; k < 8; k++) begin : g_pack
    assign bus.out_r[k*W +: W] = slot_r_q[k];
    assign bus.out_i[k*W +: W] = slot_i_q[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_input_loader.sv
// ==== tb_fft_input_loader : directed self-checking bench for fft_input_loader (rev 1.0) ====
`default_nettype none

module tb_fft_input_loader;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fft_input_loader_if #(.W(8)) bus ();

  fft_input_loader #(.N(3), .BITREV(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected bus for a frame whose sample n carries base+n (imag part negated).
  function automatic logic [63:0] exp_frame(input logic [7:0] base, input bit neg);
    int         perm [8];
    logic [7:0] v;
    logic [63:0] r;
    perm = '{0, 4, 2, 6, 1, 5, 3, 7};
    r = '0;
    for (int k = 0; k < 8; k++) begin
      v = base + 8'(perm[k]);
      if (neg) v = -v;
      r[k*8 +: 8] = v;
    end
    return r;
  endfunction

  task automatic send(input logic [7:0] v, input logic last);
    bus.in_valid = 1'b1;
    bus.in_r     = v;
    bus.in_i     = -v;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic release_frame();
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
  endtask

  initial begin
    int gaps [8];
    int s, nf, last_cyc;
    bit acc;
    logic [63:0] held_r, held_i;
    logic [7:0]  b6;

    checks = 0;
    errors = 0;
    gaps = '{0, 2, 1, 3, 0, 1, 0, 2};
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_r = '0;
    bus.in_i = '0;
    bus.frame_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_fv", 64'(bus.frame_valid), 64'd0);
    check("rst_err", 64'(bus.frame_err), 64'd0);
    check("rst_out_r", bus.out_r, 64'd0);
    check("rst_out_i", bus.out_i, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(bus.in_ready), 64'd1);

    // 1: back-to-back frame, bit-reversed placement
    for (int n = 0; n < 8; n++) send(8'(n), n == 7);
    check("t1_fv", 64'(bus.frame_valid), 64'd1);
    check("t1_ready", 64'(bus.in_ready), 64'd0);
    check("t1_err", 64'(bus.frame_err), 64'd0);
    check("t1_out_r", bus.out_r, 64'h0703_0501_0602_0400);
    check("t1_out_i", bus.out_i, exp_frame(8'h00, 1'b1));

    // 2: hold with frame_ready low while upstream keeps offering data
    held_r = bus.out_r;
    held_i = bus.out_i;
    bus.in_valid = 1'b1;
    bus.in_r = 8'hAA;
    bus.in_i = 8'h55;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t2_hold_r", bus.out_r, exp_frame(8'h00, 1'b0));
      check("t2_hold_i", bus.out_i, exp_frame(8'h00, 1'b1));
      check("t2_ready", 64'(bus.in_ready), 64'd0);
      check("t2_fv", 64'(bus.frame_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    release_frame();
    check("t2_rel_fv", 64'(bus.frame_valid), 64'd0);
    check("t2_rel_ready", 64'(bus.in_ready), 64'd1);
    check("t2_rel_r", bus.out_r, held_r);
    check("t2_rel_i", bus.out_i, held_i);

    // 3: short frame (in_last at cnt=3), then a clean frame
    for (int n = 0; n < 4; n++) send(8'(8'h80 + n), n == 3);
    check("t3_err", 64'(bus.frame_err), 64'd1);
    check("t3_fv", 64'(bus.frame_valid), 64'd0);
    @(negedge clk);
    check("t3_err_clr", 64'(bus.frame_err), 64'd0);
    for (int n = 0; n < 8; n++) send(8'(8'h10 + n), n == 7);
    check("t3_fv2", 64'(bus.frame_valid), 64'd1);
    check("t3_err2", 64'(bus.frame_err), 64'd0);
    check("t3_out_r", bus.out_r, exp_frame(8'h10, 1'b0));
    check("t3_out_i", bus.out_i, exp_frame(8'h10, 1'b1));
    release_frame();

    // 4: gapped frame without in_last on the 8th sample
    for (int n = 0; n < 8; n++) begin
      repeat (gaps[n]) @(negedge clk);
      check("t4_no_fv", 64'(bus.frame_valid), 64'd0);
      send(8'(8'h20 + n), 1'b0);
    end
    check("t4_fv", 64'(bus.frame_valid), 64'd1);
    check("t4_err", 64'(bus.frame_err), 64'd1);
    check("t4_out_r", bus.out_r, exp_frame(8'h20, 1'b0));
    check("t4_out_i", bus.out_i, exp_frame(8'h20, 1'b1));
    @(negedge clk);
    check("t4_err_clr", 64'(bus.frame_err), 64'd0);
    release_frame();

    // 5: asynchronous reset in the middle of a frame
    for (int n = 0; n < 5; n++) send(8'(8'h30 + n), 1'b0);
    #3 rst = 1'b0;
    #1;
    check("t5_out_r", bus.out_r, 64'd0);
    check("t5_out_i", bus.out_i, 64'd0);
    check("t5_fv", 64'(bus.frame_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_ready", 64'(bus.in_ready), 64'd1);
    for (int n = 0; n < 8; n++) send(8'(8'h40 + n), n == 7);
    check("t5_fv2", 64'(bus.frame_valid), 64'd1);
    check("t5_out_r2", bus.out_r, exp_frame(8'h40, 1'b0));
    check("t5_out_i2", bus.out_i, exp_frame(8'h40, 1'b1));
    release_frame();

    // 6: streaming with both handshakes tied high, 3 frames
    bus.frame_ready = 1'b1;
    s = 0;
    nf = 0;
    last_cyc = 0;
    acc = 1'b0;
    for (int c = 0; c < 60 && nf < 3; c++) begin
      @(negedge clk);
      if (bus.frame_valid) begin
        b6 = 8'(8'h50 + nf * 8);
        check("t6_out_r", bus.out_r, exp_frame(b6, 1'b0));
        check("t6_out_i", bus.out_i, exp_frame(b6, 1'b1));
        check("t6_err", 64'(bus.frame_err), 64'd0);
        if (nf > 0) check("t6_period", 64'(c - last_cyc), 64'd9);
        last_cyc = c;
        nf++;
      end
      if (acc) s++;
      bus.in_valid = 1'b1;
      bus.in_r = 8'(8'h50 + s);
      bus.in_i = -(8'(8'h50 + s));
      bus.in_last = (s % 8) == 7;
      acc = bus.in_ready;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.frame_ready = 1'b0;
    check("t6_frames", 64'(nf), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
